// File: rtl/note_tracker_pkg.sv
// ============================================================================
// note_tracker_pkg : shared types and the semitone-boundary table
// Revision: 1.0
// ============================================================================
`default_nettype none

package note_tracker_pkg;

    localparam int DEFAULT_NOTE_BASE  = 28;
    localparam int DEFAULT_NOTES_LOG2 = 6;
    localparam int BOUNDARY_ENTRIES   = 65;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LO_RD  = 4'd1,
        LO_CMP = 4'd2,
        HI_RD  = 4'd3,
        HI_CMP = 4'd4,
        SR_RD  = 4'd5,
        SR_CMP = 4'd6,
        UPD    = 4'd7,
        OOR    = 4'd8
    } tracker_state_t;

    // Lower edge of MIDI note (28+k): round(440*2^((28+k-69.5)/12)) Hz.
    localparam logic signed [15:0] BOUNDARY_TABLE [BOUNDARY_ENTRIES] = '{
        16'sd40,   16'sd42,   16'sd45,   16'sd48,   16'sd50,   16'sd53,
        16'sd57,   16'sd60,   16'sd64,   16'sd67,   16'sd71,   16'sd76,
        16'sd80,   16'sd85,   16'sd90,   16'sd95,   16'sd101,  16'sd107,
        16'sd113,  16'sd120,  16'sd127,  16'sd135,  16'sd143,  16'sd151,
        16'sd160,  16'sd170,  16'sd180,  16'sd190,  16'sd202,  16'sd214,
        16'sd226,  16'sd240,  16'sd254,  16'sd269,  16'sd285,  16'sd302,
        16'sd320,  16'sd339,  16'sd359,  16'sd381,  16'sd403,  16'sd427,
        16'sd453,  16'sd480,  16'sd508,  16'sd539,  16'sd571,  16'sd605,
        16'sd640,  16'sd679,  16'sd719,  16'sd762,  16'sd807,  16'sd855,
        16'sd906,  16'sd960,  16'sd1017, 16'sd1077, 16'sd1141, 16'sd1209,
        16'sd1281, 16'sd1357, 16'sd1438, 16'sd1523, 16'sd1614
    };

endpackage

`default_nettype wire

// File: rtl/note_boundary_rom.sv
// ============================================================================
// note_boundary_rom : registered-read boundary table, sign-extended to WIDTH
// Revision: 1.0
// ============================================================================
`default_nettype none

module note_boundary_rom
    import note_tracker_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic [6:0]              addr,
    output logic signed [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (addr < 7'(BOUNDARY_ENTRIES)) begin
            data <= WIDTH'(BOUNDARY_TABLE[addr]);
        end else begin
            data <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_tracker.sv
// ============================================================================
// note_tracker : frequency -> MIDI note via binary search, with debounce
// Revision: 1.0
// ============================================================================
`default_nettype none

module note_tracker
    import note_tracker_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NOTE_BASE     = DEFAULT_NOTE_BASE,
    parameter int NOTES_LOG2    = DEFAULT_NOTES_LOG2,
    parameter int STABLE_COUNT  = 3,
    parameter int SILENCE_COUNT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] f_in,
    input  logic                    f_in_valid,
    output logic [6:0]              note_out,
    output logic                    note_valid,
    output logic                    note_active,
    output logic                    busy,
    output logic [7:0]              dropped_count
);

    localparam int IDX_W = NOTES_LOG2 + 1;
    localparam int SPAN  = 1 << NOTES_LOG2;
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam int SIL_W = $clog2(SILENCE_COUNT + 1);

    localparam logic [IDX_W-1:0] SPAN_IDX    = IDX_W'(SPAN);
    localparam logic [CNT_W-1:0] STABLE_MAX  = CNT_W'(STABLE_COUNT);
    localparam logic [SIL_W-1:0] SILENCE_MAX = SIL_W'(SILENCE_COUNT);

    tracker_state_t          state;
    tracker_state_t          state_next;
    logic signed [WIDTH-1:0] freq;
    logic signed [WIDTH-1:0] rom_data;
    logic [6:0]              rom_addr;
    logic [IDX_W-1:0]        lo;
    logic [IDX_W-1:0]        hi;
    logic [IDX_W-1:0]        mid;
    logic [IDX_W-1:0]        mid_calc;
    logic [IDX_W-1:0]        lo_next;
    logic [IDX_W-1:0]        hi_next;
    logic                    f_ge_bound;
    logic [NOTES_LOG2-1:0]   raw;
    logic [NOTES_LOG2-1:0]   cand;
    logic [CNT_W-1:0]        stable_cnt;
    logic [CNT_W-1:0]        stable_next;
    logic [SIL_W-1:0]        silence_cnt;
    logic [SIL_W-1:0]        silence_next;
    logic [6:0]              note_new;
    logic                    publish;

    note_boundary_rom #(
        .WIDTH (WIDTH)
    ) u_rom (
        .clk  (clk_in),
        .addr (rom_addr),
        .data (rom_data)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Search and filter arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        mid_calc   = IDX_W'(({1'b0, lo} + {1'b0, hi}) >> 1);
        f_ge_bound = (freq >= rom_data);
        lo_next    = f_ge_bound ? mid : lo;
        hi_next    = f_ge_bound ? hi  : mid;
        raw        = lo[NOTES_LOG2-1:0];
        if (raw == cand) begin
            stable_next = (stable_cnt < STABLE_MAX) ? stable_cnt + 1'b1 : stable_cnt;
        end else begin
            stable_next = CNT_W'(1);
        end
        note_new     = 7'(NOTE_BASE + int'(raw));
        publish      = (stable_next == STABLE_MAX) && ((note_new != note_out) || !note_active);
        silence_next = (silence_cnt < SILENCE_MAX) ? silence_cnt + 1'b1 : silence_cnt;
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (f_in_valid) state_next = LO_RD;
            LO_RD:   state_next = LO_CMP;
            LO_CMP:  state_next = f_ge_bound ? HI_RD : OOR;
            HI_RD:   state_next = HI_CMP;
            HI_CMP:  state_next = f_ge_bound ? OOR : SR_RD;
            SR_RD:   state_next = SR_CMP;
            SR_CMP:  state_next = ((hi_next - lo_next) > IDX_W'(1)) ? SR_RD : UPD;
            UPD:     state_next = IDLE;
            OOR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: busy flag and ROM address for the coming compare
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state != IDLE);
        rom_addr = 7'd0;
        case (state)
            HI_RD:   rom_addr = 7'(SPAN);
            SR_RD:   rom_addr = 7'(mid_calc);
            default: rom_addr = 7'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, stability filter and silence tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            freq          <= '0;
            lo            <= '0;
            hi            <= '0;
            mid           <= '0;
            cand          <= '0;
            stable_cnt    <= '0;
            silence_cnt   <= '0;
            note_out      <= '0;
            note_valid    <= 1'b0;
            note_active   <= 1'b0;
            dropped_count <= '0;
        end else begin
            note_valid <= 1'b0;

            if ((state == IDLE) && f_in_valid) begin
                freq <= f_in;
            end

            // No backpressure: a strobe arriving mid-search is lost and counted.
            if ((state != IDLE) && f_in_valid && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end

            case (state)
                HI_CMP: begin
                    lo <= '0;
                    hi <= SPAN_IDX;
                end
                SR_RD: begin
                    mid <= mid_calc;
                end
                SR_CMP: begin
                    lo <= lo_next;
                    hi <= hi_next;
                end
                UPD: begin
                    cand        <= raw;
                    stable_cnt  <= stable_next;
                    silence_cnt <= '0;
                    if (publish) begin
                        note_out    <= note_new;
                        note_valid  <= 1'b1;
                        note_active <= 1'b1;
                    end
                end
                OOR: begin
                    stable_cnt  <= '0;
                    silence_cnt <= silence_next;
                    if (silence_next == SILENCE_MAX) begin
                        note_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/note_tracker.md
Name: note_tracker

Overview:
- Consumes the pitch-detector frequency stream (signed integer Hz plus a valid pulse) directly downstream of the audio-processing chain.
- Maps each estimate to a MIDI note with a sequential binary search over a semitone-boundary ROM.
- Applies a hysteresis/stability filter and presents a debounced note, a change pulse and a note-active flag to the display and synth logic.

Parameters:
- WIDTH, 32: width of the signed frequency input, integer Hz.
- NOTE_BASE, 28: MIDI number of table index 0 (E1).
- NOTES_LOG2, 6: log2 of the table span; 64 notes, 65 boundaries.
- STABLE_COUNT, 3: consecutive identical raw notes required before note_out changes.
- SILENCE_COUNT, 4: consecutive out-of-range results before note_active drops.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- f_in  input  WIDTH signed  frequency estimate in Hz.
- f_in_valid  input  1  single-cycle strobe for f_in; no backpressure.
- note_out  output  7  debounced MIDI note number.
- note_valid  output  1  one-cycle pulse when note_out takes a new value.
- note_active  output  1  high while a stable note is held.
- busy  output  1  high while a search is in progress.
- dropped_count  output  8  saturating count of strobes ignored while busy.

Behaviour:
- Reset (async, active-high): note_out=0, note_valid=0, note_active=0, busy=0, dropped_count=0. FSM returns to IDLE; candidate, stable counter and silence counter are cleared. Reset mid-search aborts the search with no output.
- Boundary ROM: B[k] = round(440*2^((NOTE_BASE+k-69.5)/12)) for k=0..64. Defaults give B[0]=40 and B[64]=1614.
  - ROM read is synchronous: address registered at edge N, data usable in the cycle after edge N.
  - All comparisons are signed and WIDTH bits wide; ROM entries are sign-extended.
- Acceptance: f_in_valid in IDLE captures f_in and busy goes high the next cycle. f_in_valid while busy is dropped and dropped_count increments, saturating at 255.
- FSM states and transitions:
  - IDLE.
  - LO_RD, then LO_CMP: f<B[0] goes to OOR; otherwise HI_RD.
  - HI_RD, then HI_CMP: f>=B[64] goes to OOR; otherwise lo=0, hi=64, then SR_RD.
  - SR_RD: mid=(lo+hi)>>1.
  - SR_CMP: f>=B[mid] sets lo=mid; otherwise hi=mid. Loops to SR_RD while hi-lo>1; otherwise UPD with raw=lo.
  - UPD, then IDLE.
  - OOR, then IDLE.
- Latency: capture edge is edge 0. The 4 range-check cycles plus NOTES_LOG2 search pairs put UPD in the cycle after edge 4+2*NOTES_LOG2, i.e. 16 by default. A resulting note_valid is high during the cycle after edge 17.
- busy deasserts on the same edge that leaves UPD or OOR. A strobe in that following cycle is accepted.
- Stability filter, evaluated in UPD:
  - raw equal to the candidate: count=min(count+1, STABLE_COUNT).
  - raw different: candidate=raw, count=1.
  - When count reaches STABLE_COUNT:
    - if NOTE_BASE+candidate differs from note_out, or note_active=0: note_out updates, note_valid pulses and note_active is set.
    - otherwise nothing changes.
  - The silence counter clears in UPD.
- OOR handling (includes zero and negative input): count=0, silence counter increments, saturating at SILENCE_COUNT. On reaching SILENCE_COUNT, note_active is cleared; note_out holds and no pulse is issued.
- note_valid is never high for two consecutive cycles.

Decomposition:
- Package note_tracker_pkg:
  - FSM state enum.
  - Defaults for NOTE_BASE and NOTES_LOG2.
  - Boundary table as a localparam array generated offline for the default parameters.
- Sub-module note_boundary_rom: 7-bit address, WIDTH-bit data, 1-cycle registered read, contents taken from the package.

Test Plan:
- Reset check: pulse rst_in asynchronously between clock edges -> all outputs 0 immediately, not waiting for the next edge.
- Three spaced strobes of f_in=440 -> no output after strobes 1 and 2; after strobe 3, note_valid is high exactly 17 cycles after its capture edge with note_out=69 and note_active=1. A fourth strobe of 440 -> no pulse.
- Range edges, each sent 3 times with a fresh reset per value:
  - 40 -> note 28.
  - 1613 -> note 91.
  - 39, 1614, 0 and -5 -> never pulse.
- Hold then silence: hold 440 until stable, then 4 strobes of 10 -> note_active falls after the 4th OOR result and note_out stays 69. Then 3 strobes of 262 -> note_valid pulses with note_out=60.
- Debounce: 440, 440, 466, 440, 440, 440 -> a single pulse (note 69) only after the sixth strobe; the candidate restarts at 466.
- Overrun: strobe every cycle for 300 cycles -> one acceptance per search window, dropped_count saturates at 255 and busy never glitches.
